vz_image_loader: RTL and testbench

- Sequences a VZ snapshot download from the HPS ioctl stream into the shared system RAM, and arbitrates the RAM write port between the Z80 and the loader.
- Parses the 24-byte VZ header, then streams the payload to its start address, then patches the BASIC/USR pointers.
- The CPU is stalled while the loader owns the port.
- Sits between hps_io and the Laser310 core RAM.

---
 rtl/vz_image_loader.sv | 205 ++++++++++++++++++++
 tb/tb_vz_image_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vz_image_loader.sv
// vz_image_loader
//   Loads a VZ snapshot from the HPS ioctl byte stream into the shared system
//   RAM. It also arbitrates the RAM write port between the Z80 and the loader.
//   Load sequence: parse the 24-byte header, stream the payload to its start
//   address, then patch the BASIC end pointer (type F0) or the USR vector
//   (type F1). The CPU is stalled for as long as the loader owns the port.
//
// Ports
//   clk_sys, reset        : system clock, asynchronous active-high reset
//   ioctl_download/index  : download window and target index from hps_io
//   ioctl_wr/addr/dout    : byte strobe, byte offset in the image, image byte
//   ioctl_wait            : backpressure to the HPS
//   cpu_addr/dout/we      : Z80 RAM write port
//   ram_addr/din/we       : muxed RAM write port
//   cpu_wait              : stalls the Z80 while the loader owns RAM
//   busy                  : loader owns RAM
//   load_ok / load_err    : outcome of the last load
//   file_type             : type byte of the last header
//
// Byte handshake (ioctl_wr / ioctl_wait):
//   A byte is accepted on a cycle where ioctl_wr=1 and ioctl_wait=0. The
//   accepting cycle raises ioctl_wait for exactly the following cycle, and the
//   RAM write happens on that same following cycle. A strobe that arrives
//   while ioctl_wait=1 is dropped, and the load is then reported as load_err.
module vz_image_loader #(
  parameter logic [7:0]  IMAGE_INDEX   = 8'd1,
  parameter logic [15:0] RAM_BASE      = 16'h7800,
  parameter logic [15:0] BASIC_END_PTR = 16'h78F9,
  parameter logic [15:0] USR_PTR       = 16'h788E
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic        cpu_wait,
  output logic        busy,
  output logic        load_ok,
  output logic        load_err,
  output logic [7:0]  file_type
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_DATA, S_PTR_LO, S_PTR_HI, S_DONE, S_ERROR
  } state_t;

  state_t      state;
  logic        dl_q;
  logic [31:0] magic;      // header bytes 0..3, byte 0 in the top byte
  logic [15:0] start;
  logic [15:0] len;
  logic        viol;       // a strobe was dropped during this load
  logic [15:0] ld_addr;
  logic [7:0]  ld_din;
  logic        ld_we;

  logic        dl_rise;
  logic        dl_fall;
  logic        violation;
  logic [15:0] data_addr;
  logic        magic_good;
  logic        type_good;
  logic [15:0] ptr_base;
  logic [15:0] ptr_val;

  assign dl_rise    = ioctl_download & ~dl_q & (ioctl_index == IMAGE_INDEX);
  assign dl_fall    = ~ioctl_download & dl_q;
  assign violation  = ioctl_wr & ioctl_wait;
  assign data_addr  = start + ioctl_addr - 16'd24;
  assign magic_good = (magic == 32'h565A_4630) || (magic == 32'h2020_0000);
  assign type_good  = (file_type == 8'hF0) || (file_type == 8'hF1);
  assign ptr_base   = (file_type == 8'hF0) ? BASIC_END_PTR : USR_PTR;
  assign ptr_val    = (file_type == 8'hF0) ? (start + len) : start;

  // While the loader owns the port the CPU cannot write at all. Reset also
  // masks the CPU strobe so the port is quiet during reset.
  assign ram_addr = busy ? ld_addr : cpu_addr;
  assign ram_din  = busy ? ld_din  : cpu_dout;
  assign ram_we   = busy ? ld_we   : (cpu_we & ~reset);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      magic      <= '0;
      start      <= '0;
      len        <= '0;
      viol       <= 1'b0;
      ld_addr    <= '0;
      ld_din     <= '0;
      ld_we      <= 1'b0;
      ioctl_wait <= 1'b0;
      cpu_wait   <= 1'b0;
      busy       <= 1'b0;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
      file_type  <= '0;
    end else begin
      dl_q       <= ioctl_download;
      ld_we      <= 1'b0;
      ioctl_wait <= 1'b0;

      // A matching download start always wins, whatever the current state.
      if (dl_rise) begin
        state    <= S_HEADER;
        load_ok  <= 1'b0;
        load_err <= 1'b0;
        len      <= '0;
        magic    <= '0;
        viol     <= 1'b0;
        busy     <= 1'b1;
        cpu_wait <= 1'b1;
      end else begin
        case (state)
          S_IDLE: ;

          S_HEADER: begin
            if (dl_fall) begin
              state <= S_ERROR;
            end else if (violation) begin
              viol <= 1'b1;
            end else if (ioctl_wr) begin
              ioctl_wait <= 1'b1;
              case (ioctl_addr)
                16'd0:  magic[31:24] <= ioctl_dout;
                16'd1:  magic[23:16] <= ioctl_dout;
                16'd2:  magic[15:8]  <= ioctl_dout;
                16'd3:  magic[7:0]   <= ioctl_dout;
                16'd21: file_type    <= ioctl_dout;
                16'd22: start[7:0]   <= ioctl_dout;
                16'd23: begin
                  start[15:8] <= ioctl_dout;
                  state       <= (magic_good && type_good) ? S_DATA : S_ERROR;
                end
                default: ;
              endcase
            end
          end

          S_DATA: begin
            if (dl_fall) begin
              state <= S_PTR_LO;
            end else if (violation) begin
              viol <= 1'b1;
            end else if (ioctl_wr) begin
              ioctl_wait <= 1'b1;
              if (len != 16'hFFFF) len <= len + 16'd1;
              // Bytes aimed below writable RAM still count toward the length.
              if (data_addr >= RAM_BASE) begin
                ld_we   <= 1'b1;
                ld_addr <= data_addr;
                ld_din  <= ioctl_dout;
              end
            end
          end

          S_PTR_LO: begin
            ld_we   <= 1'b1;
            ld_addr <= ptr_base;
            ld_din  <= ptr_val[7:0];
            state   <= S_PTR_HI;
          end

          S_PTR_HI: begin
            ld_we   <= 1'b1;
            ld_addr <= ptr_base + 16'd1;
            ld_din  <= ptr_val[15:8];
            state   <= S_DONE;
          end

          S_DONE: begin
            busy     <= 1'b0;
            cpu_wait <= 1'b0;
            load_ok  <= ~viol;
            load_err <= viol;
            state    <= S_IDLE;
          end

          S_ERROR: begin
            // Bytes are swallowed until the download window closes. This also
            // covers a truncated header, where the window has already closed.
            if (!ioctl_download) begin
              load_err <= 1'b1;
              busy     <= 1'b0;
              cpu_wait <= 1'b0;
              state    <= S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vz_image_loader.sv
module tb_vz_image_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd1;
  logic        ioctl_wr = 1'b0;
  logic [15:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_we = 1'b0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        cpu_wait;
  logic        busy;
  logic        load_ok;
  logic        load_err;
  logic [7:0]  file_type;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  vz_image_loader dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .cpu_wait(cpu_wait), .busy(busy), .load_ok(load_ok),
    .load_err(load_err), .file_type(file_type)
  );

  // RAM model fed by the muxed write port
  logic [7:0] mem [0:65535];
  int wr_count = 0;
  always @(posedge clk_sys) begin
    if (ram_we === 1'b1) begin
      mem[ram_addr] <= ram_din;
      wr_count <= wr_count + 1;
    end
  end

  // driver tasks
  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk_sys); #1;
    ioctl_index = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] magic, input logic [7:0] ftype,
                             input logic [15:0] st, input int nbytes);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      case (i)
        0: b = magic[31:24];
        1: b = magic[23:16];
        2: b = magic[15:8];
        3: b = magic[7:0];
        21: b = ftype;
        22: b = st[7:0];
        23: b = st[15:8];
        default: b = 8'h41;
      endcase
      send_byte(16'(i), b);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy !== 1'b0; i++) begin
      @(posedge clk_sys); #1;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy did not clear, got %b want 0", name, busy);
    end
  endtask

  task automatic end_dl(input string name);
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    wait_idle(name);
  endtask

  // tests
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk_sys); #1;
    checks++;
    if ({ioctl_wait, ram_we, cpu_wait, busy, load_ok, load_err, file_type} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {ioctl_wait, ram_we, cpu_wait, busy, load_ok, load_err, file_type});
    end
    reset = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic test_valid_f1;
    start_dl(8'd1);
    send_header(32'h565A4630, 8'hF1, 16'h8000, 24);
    checks++;
    if (busy !== 1'b1 || cpu_wait !== 1'b1) begin
      errors++;
      $display("FAIL f1_busy: busy=%b cpu_wait=%b want 1 1", busy, cpu_wait);
    end
    // first payload byte, checked cycle by cycle
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_addr = 16'd24; ioctl_dout = 8'hAA;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    checks++;
    if (ram_we !== 1'b1 || ioctl_wait !== 1'b1 || ram_addr !== 16'h8000 || ram_din !== 8'hAA) begin
      errors++;
      $display("FAIL f1_write_cycle: we=%b wait=%b addr=%h din=%h want 1 1 8000 aa",
               ram_we, ioctl_wait, ram_addr, ram_din);
    end
    @(posedge clk_sys); #1;
    checks++;
    if (ram_we !== 1'b0 || ioctl_wait !== 1'b0) begin
      errors++;
      $display("FAIL f1_write_one_cycle: we=%b wait=%b want 0 0", ram_we, ioctl_wait);
    end
    send_byte(16'd25, 8'hBB);
    send_byte(16'd26, 8'hCC);
    end_dl("f1_done");
    checks++;
    if ({mem[16'h8000], mem[16'h8001], mem[16'h8002]} !== 24'hAABBCC) begin
      errors++;
      $display("FAIL f1_payload: got %h%h%h want aabbcc",
               mem[16'h8000], mem[16'h8001], mem[16'h8002]);
    end
    checks++;
    if (mem[16'h788E] !== 8'h00 || mem[16'h788F] !== 8'h80) begin
      errors++;
      $display("FAIL f1_usr_ptr: got %h %h want 00 80", mem[16'h788E], mem[16'h788F]);
    end
    checks++;
    if (load_ok !== 1'b1 || load_err !== 1'b0 || file_type !== 8'hF1 || cpu_wait !== 1'b0) begin
      errors++;
      $display("FAIL f1_status: ok=%b err=%b type=%h cpu_wait=%b want 1 0 f1 0",
               load_ok, load_err, file_type, cpu_wait);
    end
  endtask

  task automatic test_valid_f0;
    start_dl(8'd1);
    send_header(32'h565A4630, 8'hF0, 16'h7AE9, 24);
    for (int i = 0; i < 256; i++) send_byte(16'(24 + i), 8'(i));
    end_dl("f0_done");
    checks++;
    if (mem[16'h78F9] !== 8'hE9 || mem[16'h78FA] !== 8'h7B) begin
      errors++;
      $display("FAIL f0_end_ptr: got %h %h want e9 7b", mem[16'h78F9], mem[16'h78FA]);
    end
    checks++;
    if (mem[16'h7AE9] !== 8'h00 || mem[16'h7BE8] !== 8'hFF) begin
      errors++;
      $display("FAIL f0_payload: got %h %h want 00 ff", mem[16'h7AE9], mem[16'h7BE8]);
    end
    checks++;
    if (load_ok !== 1'b1 || file_type !== 8'hF0) begin
      errors++;
      $display("FAIL f0_status: ok=%b type=%h want 1 f0", load_ok, file_type);
    end
  endtask

  task automatic test_bad_magic;
    int w0;
    w0 = wr_count;
    start_dl(8'd1);
    checks++;
    @(posedge clk_sys); #1;
    if (load_ok !== 1'b0) begin
      errors++;
      $display("FAIL bad_magic_ok_cleared: got %b want 0", load_ok);
    end
    send_header(32'h41424344, 8'hF1, 16'h8000, 24);
    send_byte(16'd24, 8'h11);
    send_byte(16'd25, 8'h22);
    end_dl("bad_magic_done");
    checks++;
    if (wr_count !== w0) begin
      errors++;
      $display("FAIL bad_magic_writes: got %0d want 0", wr_count - w0);
    end
    checks++;
    if (load_err !== 1'b1 || load_ok !== 1'b0) begin
      errors++;
      $display("FAIL bad_magic_status: err=%b ok=%b want 1 0", load_err, load_ok);
    end
  endtask

  task automatic test_truncation;
    int w0;
    w0 = wr_count;
    start_dl(8'd1);
    send_header(32'h20200000, 8'hF1, 16'h8000, 10);
    end_dl("trunc_done");
    checks++;
    if (load_err !== 1'b1 || wr_count !== w0 || cpu_wait !== 1'b0) begin
      errors++;
      $display("FAIL truncation: err=%b writes=%0d cpu_wait=%b want 1 0 0",
               load_err, wr_count - w0, cpu_wait);
    end
  endtask

  task automatic test_arbitration;
    start_dl(8'd1);
    send_header(32'h20200000, 8'hF1, 16'hA000, 5);
    @(posedge clk_sys); #1;
    cpu_we = 1'b1; cpu_addr = 16'h9000; cpu_dout = 8'h55;
    checks++;
    if (ram_we !== 1'b0 || cpu_wait !== 1'b1) begin
      errors++;
      $display("FAIL arb_blocked: ram_we=%b cpu_wait=%b want 0 1", ram_we, cpu_wait);
    end
    @(posedge clk_sys); #1;
    cpu_we = 1'b0;
    for (int i = 5; i < 24; i++)
      send_byte(16'(i), (i == 21) ? 8'hF1 : (i == 23) ? 8'hA0 : 8'h00);
    send_byte(16'd24, 8'h77);
    end_dl("arb_done");
    checks++;
    if (mem[16'h9000] === 8'h55 || mem[16'hA000] !== 8'h77) begin
      errors++;
      $display("FAIL arb_during_load: mem9000=%h memA000=%h want not-55 77",
               mem[16'h9000], mem[16'hA000]);
    end
    @(posedge clk_sys); #1;
    cpu_we = 1'b1; cpu_addr = 16'h9000; cpu_dout = 8'h55;
    @(posedge clk_sys); #1;
    cpu_we = 1'b0;
    checks++;
    if (mem[16'h9000] !== 8'h55) begin
      errors++;
      $display("FAIL arb_after_load: got %h want 55", mem[16'h9000]);
    end
  endtask

  task automatic test_skip_low;
    int w0;
    w0 = wr_count;
    start_dl(8'd1);
    send_header(32'h565A4630, 8'hF1, 16'h77FE, 24);
    send_byte(16'd24, 8'h11);
    send_byte(16'd25, 8'h22);
    send_byte(16'd26, 8'h33);
    send_byte(16'd27, 8'h44);
    end_dl("skip_done");
    checks++;
    if (wr_count - w0 !== 4) begin
      errors++;
      $display("FAIL skip_write_count: got %0d want 4", wr_count - w0);
    end
    checks++;
    if (mem[16'h7800] !== 8'h33 || mem[16'h7801] !== 8'h44) begin
      errors++;
      $display("FAIL skip_payload: got %h %h want 33 44", mem[16'h7800], mem[16'h7801]);
    end
    checks++;
    if (mem[16'h788E] !== 8'hFE || mem[16'h788F] !== 8'h77) begin
      errors++;
      $display("FAIL skip_usr_ptr: got %h %h want fe 77", mem[16'h788E], mem[16'h788F]);
    end
  endtask

  task automatic test_protocol_violation;
    int w0;
    start_dl(8'd1);
    send_header(32'h565A4630, 8'hF1, 16'h8100, 24);
    w0 = wr_count;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_addr = 16'd24; ioctl_dout = 8'h5A;
    @(posedge clk_sys); #1;
    ioctl_addr = 16'd25; ioctl_dout = 8'h5B;  // strobe held into the wait cycle
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    end_dl("viol_done");
    checks++;
    if (load_err !== 1'b1 || load_ok !== 1'b0) begin
      errors++;
      $display("FAIL viol_status: err=%b ok=%b want 1 0", load_err, load_ok);
    end
    checks++;
    if (mem[16'h8100] !== 8'h5A || wr_count - w0 !== 3) begin
      errors++;
      $display("FAIL viol_writes: mem=%h count=%0d want 5a 3", mem[16'h8100], wr_count - w0);
    end
  endtask

  task automatic test_reset_mid_data;
    start_dl(8'd1);
    send_header(32'h565A4630, 8'hF1, 16'h8200, 24);
    send_byte(16'd24, 8'h01);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_addr = 16'd25; ioctl_dout = 8'h02;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    reset = 1'b1;
    ioctl_download = 1'b0;
    #1;
    checks++;
    if ({ioctl_wait, ram_we, cpu_wait, busy, load_ok, load_err, file_type} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid_data: got %b want 0",
               {ioctl_wait, ram_we, cpu_wait, busy, load_ok, load_err, file_type});
    end
    repeat (2) @(posedge clk_sys); #1;
    reset = 1'b0;
    start_dl(8'd0);
    send_byte(16'd0, 8'h56);
    checks++;
    if (busy !== 1'b0 || cpu_wait !== 1'b0) begin
      errors++;
      $display("FAIL wrong_index: busy=%b cpu_wait=%b want 0 0", busy, cpu_wait);
    end
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  initial begin
    test_reset();
    test_valid_f1();
    test_valid_f0();
    test_bad_magic();
    test_truncation();
    test_arbitration();
    test_skip_low();
    test_protocol_violation();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
